wb_spi_slave: RTL and testbench

SPI responder (mode 0, 8-bit, MSB first) with a Wishbone slave register interface, the far end of the SPI link driven by the system's SPI master. It lets the LM32 SoC be addressed by an external SPI host. Received bytes are buffered in a small RX FIFO, and the CPU preloads the byte returned on MISO. It sits on a free conbus slave port and can drive one `intr_n` line.

---
 rtl/wb_spi_slave.sv | 203 ++++++++++++++++++++
 tb/tb_wb_spi_slave.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_slave.sv
// Mode-0 SPI responder behind a Wishbone register window: RX FIFO for host bytes,
// one TX holding byte returned on MISO, idle byte when nothing is pending.
module wb_spi_slave #(
  parameter int         rx_depth_log2 = 2,
  parameter logic [7:0] idle_byte     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso
);

  localparam int depth = 2 ** rx_depth_log2;
  localparam logic [rx_depth_log2:0]   full_count = {1'b1, {rx_depth_log2{1'b0}}};
  localparam logic [rx_depth_log2:0]   count_one  = (rx_depth_log2 + 1)'(1);
  localparam logic [rx_depth_log2-1:0] ptr_one    = (rx_depth_log2)'(1);

  typedef enum logic [1:0] {
    REG_RXDATA = 2'd0,
    REG_TXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  logic [2:0] sck_sync, cs_sync;
  logic [1:0] mosi_sync, sync_valid;
  logic       sck_rise, sck_fall, cs_fall, cs_rise, cs_active;
  logic       armed, in_frame, skip_fall, frame_active, frame_start, byte_done, reload;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out, tx_hold, load_byte, rx_byte;
  logic       tx_full, overrun, rxie;

  logic [7:0]               rx_mem [depth];
  logic [rx_depth_log2-1:0] wr_ptr, rd_ptr;
  logic [rx_depth_log2:0]   rx_count;
  logic                     rx_avail, rx_full, rx_push, rx_pop;

  reg_sel_e reg_sel;
  logic     wb_acc, wb_rd, wb_wr, tx_write, ovr_clear;
  logic     unused_inputs;

  assign unused_inputs = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

  // sync_valid marks when stage 2 holds a real pin sample rather than a reset value,
  // so the reset value of cs_n cannot arm a frame on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync   <= 3'b000;
      cs_sync    <= 3'b111;
      mosi_sync  <= 2'b00;
      sync_valid <= 2'b00;
    end else begin
      sck_sync   <= {sck_sync[1:0], spi_sck};
      cs_sync    <= {cs_sync[1:0], spi_cs_n};
      mosi_sync  <= {mosi_sync[0], spi_mosi};
      sync_valid <= {sync_valid[0], 1'b1};
    end
  end

  assign sck_rise     = sck_sync[1] & ~sck_sync[2];
  assign sck_fall     = ~sck_sync[1] & sck_sync[2];
  assign cs_fall      = ~cs_sync[1] & cs_sync[2];
  assign cs_rise      = cs_sync[1] & ~cs_sync[2];
  assign cs_active    = ~cs_sync[1];
  assign frame_active = in_frame & cs_active;
  assign frame_start  = armed & cs_fall;
  assign byte_done    = frame_active & sck_rise & (bit_cnt == 3'd7);
  assign reload       = frame_start | byte_done;
  assign load_byte    = tx_full ? tx_hold : idle_byte;
  assign rx_byte      = {shift_in, mosi_sync[1]};
  assign spi_miso     = in_frame & shift_out[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      armed     <= 1'b0;
      in_frame  <= 1'b0;
      skip_fall <= 1'b0;
      bit_cnt   <= 3'd0;
      shift_in  <= 7'd0;
      shift_out <= 8'd0;
    end else begin
      if (sync_valid[1] & cs_sync[1])
        armed <= 1'b1;
      if (frame_start) begin
        in_frame  <= 1'b1;
        skip_fall <= 1'b0;
        bit_cnt   <= 3'd0;
        shift_out <= load_byte;
      end else if (cs_rise) begin
        in_frame  <= 1'b0;
        skip_fall <= 1'b0;
        bit_cnt   <= 3'd0;
      end else if (frame_active) begin
        if (sck_rise) begin
          shift_in <= rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            bit_cnt   <= 3'd0;
            shift_out <= load_byte;
            skip_fall <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else if (sck_fall) begin
          // The fall right after a reload would discard the new byte's MSB.
          if (skip_fall)
            skip_fall <= 1'b0;
          else
            shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

  assign reg_sel   = reg_sel_e'(wb_adr_i[3:2]);
  assign wb_acc    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wb_rd     = wb_acc & ~wb_we_i;
  assign wb_wr     = wb_acc & wb_we_i;
  assign tx_write  = wb_wr & (reg_sel == REG_TXDATA);
  assign ovr_clear = wb_wr & (reg_sel == REG_STATUS) & wb_dat_i[3];
  assign rx_pop    = wb_rd & (reg_sel == REG_RXDATA) & rx_avail;

  // A same-cycle write takes effect after the reload has taken the old byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full <= 1'b0;
      tx_hold <= 8'd0;
    end else begin
      if (reload)
        tx_full <= 1'b0;
      if (tx_write) begin
        tx_hold <= wb_dat_i[7:0];
        tx_full <= 1'b1;
      end
    end
  end

  assign rx_avail = (rx_count != '0);
  assign rx_full  = (rx_count == full_count);
  assign rx_push  = byte_done & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      overrun  <= 1'b0;
    end else begin
      if (rx_push)
        wr_ptr <= wr_ptr + ptr_one;
      if (rx_pop)
        rd_ptr <= rd_ptr + ptr_one;
      if (rx_push & ~rx_pop)
        rx_count <= rx_count + count_one;
      else if (~rx_push & rx_pop)
        rx_count <= rx_count - count_one;
      if (ovr_clear)
        overrun <= 1'b0;
      if (byte_done & rx_full & ~rx_pop)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      rxie     <= 1'b0;
    end else begin
      wb_ack_o <= wb_acc;
      wb_dat_o <= 32'd0;
      if (wb_rd) begin
        case (reg_sel)
          REG_RXDATA: wb_dat_o <= {24'd0, rx_avail ? rx_mem[rd_ptr] : 8'h00};
          REG_STATUS: wb_dat_o <= {27'd0, cs_active, overrun, tx_full, rx_full, rx_avail};
          REG_CTRL:   wb_dat_o <= {31'd0, rxie};
          default:    wb_dat_o <= 32'd0;
        endcase
      end
      if (wb_wr & (reg_sel == REG_CTRL))
        rxie <= wb_dat_i[0];
    end
  end

  assign intr = rxie & rx_avail;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Randomized bench for wb_spi_slave: an SPI host model and Wishbone master feed a
// queue-based reference model, and a monitor process scores every ack and MISO byte.
module tb_wb_spi_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [3:0]  wb_sel_i;
  logic        intr, spi_sck, spi_mosi, spi_cs_n, spi_miso;

  always #5 clk = ~clk;

  wb_spi_slave dut (
    .clk      (clk),
    .reset    (reset),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_ack_o (wb_ack_o),
    .intr     (intr),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n),
    .spi_miso (spi_miso)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    string       name;
  } wb_exp_t;

  wb_exp_t    wb_q[$];
  wb_exp_t    mon_e;
  logic [7:0] exp_miso_q[$];
  logic [7:0] got_miso_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         ack_prev = 1'b0;

  // Reference model state
  logic [7:0] m_fifo[$];
  bit         m_tx_full, m_overrun, m_rxie, cs_low;
  logic [7:0] m_tx;
  logic [7:0] frame_data [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] model_reload();
    if (m_tx_full) begin
      m_tx_full = 1'b0;
      return m_tx;
    end
    return 8'hFF;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (m_fifo.size() < 4) m_fifo.push_back(b);
    else m_overrun = 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    return {27'd0, cs_low, m_overrun, m_tx_full, (m_fifo.size() == 4), (m_fifo.size() != 0)};
  endfunction

  always @(negedge clk) begin
    if (wb_ack_o) begin
      checkOutput("ack_one_cycle", {31'd0, ack_prev}, 32'd0);
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ack_unexpected: ack seen with no access outstanding");
      end else begin
        mon_e = wb_q.pop_front();
        if (mon_e.is_read) checkOutput(mon_e.name, wb_dat_o, mon_e.data);
      end
    end
    ack_prev = wb_ack_o;
    while (exp_miso_q.size() != 0 && got_miso_q.size() != 0)
      checkOutput("miso_byte", {24'd0, got_miso_q.pop_front()}, {24'd0, exp_miso_q.pop_front()});
  end

  task automatic applyStimulus(input bit we, input logic [1:0] rsel, input logic [7:0] data, input string name);
    wb_exp_t e;
    int n;
    e.is_read = !we;
    e.name    = name;
    e.data    = 32'd0;
    if (!we) begin
      case (rsel)
        2'd0:    if (m_fifo.size() != 0) e.data = {24'd0, m_fifo.pop_front()};
        2'd2:    e.data = model_status();
        2'd3:    e.data = {31'd0, m_rxie};
        default: e.data = 32'd0;
      endcase
    end else begin
      case (rsel)
        2'd1: begin m_tx = data; m_tx_full = 1'b1; end
        2'd2: if (data[3]) m_overrun = 1'b0;
        2'd3: m_rxie = data[0];
        default: ;
      endcase
    end
    wb_q.push_back(e);
    @(negedge clk);
    wb_adr_i = {28'($urandom), rsel, 2'($urandom)};
    wb_dat_i = {24'($urandom), data};
    wb_sel_i = 4'($urandom);
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 8);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!wb_ack_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout %s: no ack within 8 cycles", name);
      void'(wb_q.pop_back());
    end
  endtask

  // race_kind 1 = RXDATA read, 2 = TXDATA write, aligned with the last byte's 8th edge
  task automatic spiFrame(input int nbytes, input int abort_bits, input int race_kind, input logic [7:0] race_data);
    logic [7:0] cur_exp, next_exp, got;
    int bits_sent;
    bits_sent = 0;
    next_exp  = 8'd0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    cs_low   = 1'b1;
    cur_exp  = model_reload();
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbytes; b++) begin
      if (abort_bits == 0) exp_miso_q.push_back(cur_exp);
      got = 8'd0;
      for (int i = 7; i >= 0; i--) begin
        if (abort_bits != 0 && bits_sent == abort_bits) break;
        spi_mosi = frame_data[b][i];
        repeat (5) @(negedge clk);
        got[i]  = spi_miso;
        spi_sck = 1'b1;
        if (i == 0) next_exp = model_reload();
        fork
          repeat (5) @(negedge clk);
          if (i == 0 && b == nbytes - 1 && race_kind != 0) begin
            @(negedge clk);
            applyStimulus(race_kind == 2, (race_kind == 2) ? 2'd1 : 2'd0, race_data, "race_rxdata");
          end
        join
        spi_sck = 1'b0;
        bits_sent++;
      end
      if (abort_bits == 0) begin
        model_push(frame_data[b]);
        got_miso_q.push_back(got);
        cur_exp = next_exp;
      end
    end
    repeat (5) @(negedge clk);
    spi_cs_n = 1'b1;
    cs_low   = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic sckPulses(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'($urandom);
      repeat (5) @(negedge clk);
      spi_sck = 1'b1;
      repeat (5) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_fifo.delete();
    m_tx_full = 1'b0;
    m_overrun = 1'b0;
    m_rxie    = 1'b0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset_ack", {31'd0, wb_ack_o}, 32'd0);
    checkOutput("reset_dat", wb_dat_o, 32'd0);
    checkOutput("reset_intr", {31'd0, intr}, 32'd0);
    checkOutput("reset_miso", {31'd0, spi_miso}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nb, nr;
    reset = 1'b0;
    wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'd0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; cs_low = 1'b0;
    m_tx = 8'd0;

    doReset();
    checkResetOutputs();
    applyStimulus(1'b0, 2'd2, 8'd0, "status_reset");
    applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_empty");
    applyStimulus(1'b0, 2'd1, 8'd0, "txdata_read");

    // Basic exchange
    applyStimulus(1'b1, 2'd1, 8'hA5, "");
    applyStimulus(1'b0, 2'd2, 8'd0, "status_tx_full");
    frame_data[0] = 8'h3C;
    spiFrame(1, 0, 0, 8'd0);
    applyStimulus(1'b0, 2'd2, 8'd0, "status_after_rx");
    applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_basic");
    applyStimulus(1'b0, 2'd2, 8'd0, "status_after_read");

    // Idle byte
    frame_data[0] = 8'h01;
    frame_data[1] = 8'h02;
    spiFrame(2, 0, 0, 8'd0);
    applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_idle0");
    applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_idle1");

    // Overrun
    for (int i = 0; i < 5; i++) frame_data[i] = 8'h10 + 8'(i);
    spiFrame(5, 0, 0, 8'd0);
    applyStimulus(1'b0, 2'd2, 8'd0, "status_overrun");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_overrun");
    applyStimulus(1'b1, 2'd2, 8'h08, "");
    applyStimulus(1'b0, 2'd2, 8'd0, "status_ovr_cleared");

    // Abort mid-byte
    frame_data[0] = 8'($urandom);
    spiFrame(1, 5, 0, 8'd0);
    applyStimulus(1'b0, 2'd2, 8'd0, "status_abort");
    frame_data[0] = 8'h55;
    spiFrame(1, 0, 0, 8'd0);
    applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_after_abort");

    // Interrupt and simultaneous push/pop on a full FIFO
    applyStimulus(1'b1, 2'd3, 8'h01, "");
    applyStimulus(1'b0, 2'd3, 8'd0, "ctrl_read");
    for (int i = 0; i < 4; i++) frame_data[i] = 8'($urandom);
    spiFrame(4, 0, 0, 8'd0);
    checkOutput("intr_full", {31'd0, intr}, {31'd0, m_rxie && m_fifo.size() != 0});
    frame_data[0] = 8'($urandom);
    spiFrame(1, 0, 1, 8'd0);
    applyStimulus(1'b0, 2'd2, 8'd0, "status_race_pop");
    checkOutput("intr_after_race", {31'd0, intr}, {31'd0, m_rxie && m_fifo.size() != 0});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_drain");
      checkOutput("intr_drain", {31'd0, intr}, {31'd0, m_rxie && m_fifo.size() != 0});
    end

    // TXDATA write coinciding with a reload
    frame_data[0] = 8'($urandom);
    spiFrame(1, 0, 2, 8'hC3);
    applyStimulus(1'b0, 2'd2, 8'd0, "status_tx_race");
    frame_data[0] = 8'($urandom);
    spiFrame(1, 0, 0, 8'd0);
    applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_tx_race");

    // Randomized traffic
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, 2'd1, 8'($urandom), "");
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 2'd3, 8'($urandom), "");
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) frame_data[j] = 8'($urandom);
      spiFrame(nb, 0, 0, 8'd0);
      applyStimulus(1'b0, 2'd2, 8'd0, "status_rand");
      checkOutput("intr_rand", {31'd0, intr}, {31'd0, m_rxie && m_fifo.size() != 0});
      nr = $urandom_range(0, 4);
      for (int j = 0; j < nr; j++) applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_rand");
      if ($urandom_range(0, 2) == 0) applyStimulus(1'b1, 2'd2, 8'($urandom), "");
    end

    // Reset in the middle of a byte with cs_n held low
    @(negedge clk);
    spi_cs_n = 1'b0;
    cs_low   = 1'b1;
    repeat (6) @(negedge clk);
    sckPulses(3);
    doReset();
    checkResetOutputs();
    sckPulses(8);
    checkOutput("miso_unarmed", {31'd0, spi_miso}, 32'd0);
    applyStimulus(1'b0, 2'd2, 8'd0, "status_unarmed");
    spi_cs_n = 1'b1;
    cs_low   = 1'b0;
    repeat (8) @(negedge clk);
    frame_data[0] = 8'($urandom);
    spiFrame(1, 0, 0, 8'd0);
    applyStimulus(1'b0, 2'd0, 8'd0, "rxdata_after_reset");

    repeat (10) @(negedge clk);
    checkOutput("sb_wb_drain", 32'(wb_q.size()), 32'd0);
    checkOutput("sb_miso_exp_drain", 32'(exp_miso_q.size()), 32'd0);
    checkOutput("sb_miso_got_drain", 32'(got_miso_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
